// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU types, default array dimensions and the ReLU helper.
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } ctrl_state_t;

    localparam int NPU_N      = 4;
    localparam int NPU_DATA_W = 8;
    localparam int NPU_ACC_W  = 32;

    function automatic logic signed [NPU_ACC_W-1:0] relu(input logic signed [NPU_ACC_W-1:0] v);
        return v[NPU_ACC_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - N-lane delay line, lane i delayed by i registers.
module skew_buffer #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] lane_data,
    output logic [N*W-1:0] skew_data
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign skew_data[W-1:0] = lane_data[W-1:0];
        end else begin : g_dly
            logic [W-1:0] pipe [i];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) pipe[s] <= '0;
                end else begin
                    pipe[0] <= lane_data[i*W +: W];
                    for (int s = 1; s < i; s++) pipe[s] <= pipe[s-1];
                end
            end

            assign skew_data[i*W +: W] = pipe[i-1];
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - output-stationary systolic array sequencer: clear, feed
// skewed operands, drain the wavefront, then stream the N x N results.
module systolic_ctrl
    import npu_pkg::*;
#(
    parameter int N      = NPU_N,
    parameter int K_MAX  = 16,
    parameter int DATA_W = NPU_DATA_W,
    parameter int ACC_W  = NPU_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic                         relu_en,
    output logic                         busy,
    output logic                         done,
    output logic                         op_rd_en,
    output logic [$clog2(K_MAX)-1:0]     op_rd_addr,
    input  logic [N*DATA_W-1:0]          a_rd_data,
    input  logic [N*DATA_W-1:0]          b_rd_data,
    output logic                         arr_clr,
    output logic [N*DATA_W-1:0]          west_data,
    output logic [N*DATA_W-1:0]          north_data,
    input  logic [N*N*ACC_W-1:0]         res_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [$clog2(N)-1:0]         out_row,
    output logic [$clog2(N)-1:0]         out_col
);

    localparam int KW  = $clog2(K_MAX+1);
    localparam int AW  = $clog2(K_MAX);
    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2*N);

    ctrl_state_t state, state_next;

    logic [KW-1:0]       k_len_q;
    logic                relu_q;
    logic [AW-1:0]       feed_cnt;
    logic [DCW-1:0]      drain_cnt;
    logic [RW-1:0]       row_q;
    logic [RW-1:0]       col_q;
    logic                rd_vld_q;
    logic [N*DATA_W-1:0] a_q;
    logic [N*DATA_W-1:0] b_q;
    logic                arr_clr_q;
    logic                done_q;

    logic                start_ok;
    logic                hs;
    logic                last_elem;
    logic                feed_last;
    logic                drain_last;
    logic signed [ACC_W-1:0] res_sel;

    assign start_ok   = start && (k_len != '0) && (k_len <= KW'(K_MAX));
    assign hs         = (state == OUT) && out_ready;
    assign last_elem  = (row_q == RW'(N-1)) && (col_q == RW'(N-1));
    assign feed_last  = (KW'(feed_cnt) == k_len_q - KW'(1));
    assign drain_last = (drain_cnt == DCW'(2*N-1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (feed_last) state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = OUT;
            OUT:     if (hs && last_elem) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q   <= '0;
            relu_q    <= 1'b0;
            feed_cnt  <= '0;
            drain_cnt <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rd_vld_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            arr_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (state == IDLE && start_ok) begin
                k_len_q <= k_len;
                relu_q  <= relu_en;
            end
            feed_cnt  <= (state == FEED && !feed_last) ? feed_cnt + AW'(1) : '0;
            drain_cnt <= (state == DRAIN && !drain_last) ? drain_cnt + DCW'(1) : '0;
            if (hs) begin
                if (col_q == RW'(N-1)) begin
                    col_q <= '0;
                    row_q <= (row_q == RW'(N-1)) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + RW'(1);
                end
            end
            // Zero-gate stale SRAM output so the array only ever accumulates real products.
            rd_vld_q  <= op_rd_en;
            a_q       <= rd_vld_q ? a_rd_data : '0;
            b_q       <= rd_vld_q ? b_rd_data : '0;
            arr_clr_q <= (state_next == CLEAR);
            done_q    <= hs && last_elem;
        end
    end

    skew_buffer #(.N(N), .W(DATA_W)) u_west_skew (
        .clk       (clk),
        .rst       (rst),
        .lane_data (a_q),
        .skew_data (west_data)
    );

    skew_buffer #(.N(N), .W(DATA_W)) u_north_skew (
        .clk       (clk),
        .rst       (rst),
        .lane_data (b_q),
        .skew_data (north_data)
    );

    assign res_sel    = res_in[(int'(row_q)*N + int'(col_q))*ACC_W +: ACC_W];
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign arr_clr    = arr_clr_q;
    assign op_rd_en   = (state == FEED);
    assign op_rd_addr = feed_cnt;
    assign out_valid  = (state == OUT);
    assign out_data   = out_valid ? (relu_q ? relu(res_sel) : res_sel) : '0;
    assign out_row    = row_q;
    assign out_col    = col_q;

endmodule
